// File: rtl/rv32im_types.sv
// Shared RV32IM types: base opcodes plus the BTB write-port encoding and update-FIFO entry.
package rv32im_types;

  typedef enum logic [6:0] {
    op_b_lui   = 7'b0110111,
    op_b_auipc = 7'b0010111,
    op_b_jal   = 7'b1101111,
    op_b_jalr  = 7'b1100111,
    op_b_br    = 7'b1100011,
    op_b_load  = 7'b0000011,
    op_b_store = 7'b0100011,
    op_b_imm   = 7'b0010011,
    op_b_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    WR_BR    = 2'd0,
    WR_JMP   = 2'd1,
    WR_INVAL = 2'd2
  } btb_wr_op_t;

  typedef struct packed {
    btb_wr_op_t  op;
    logic [31:0] pc;
    logic [31:0] target;
  } btb_upd_entry_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of pending BTB updates; clear empties it and overrides push/pop.
module btb_upd_fifo
  import rv32im_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  btb_upd_entry_t wdata,
  input  logic           pop,
  input  logic           clear,
  output btb_upd_entry_t rdata,
  output logic           full,
  output logic           empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  btb_upd_entry_t mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (do_pop && !do_push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; empty gates every use of rdata.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Serialises ROB-commit BTB updates and full-BTB invalidate sweeps onto one write port.
module btb_update_ctrl
  import rv32im_types::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BTB_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_valid,
  output logic                 commit_ready,
  input  logic [31:0]          commit_pc,
  input  logic [31:0]          commit_pc_next,
  input  logic [6:0]           commit_opcode,
  input  logic                 commit_taken,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 btb_wr_valid,
  input  logic                 btb_wr_ready,
  output btb_wr_op_t           btb_wr_op,
  output logic [BTB_DEPTH-1:0] btb_wr_index,
  output logic [31:0]          btb_wr_pc,
  output logic [31:0]          btb_wr_target
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [BTB_DEPTH-1:0] SweepLast = '1;

  logic [1:0]           state_q, state_d;
  logic [BTB_DEPTH-1:0] sweep_q, sweep_d;

  logic           is_br, qualifying;
  logic           fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  btb_upd_entry_t fifo_wdata, fifo_head;

  assign is_br      = (commit_opcode == op_b_br);
  assign qualifying = commit_valid &&
                      ((is_br && commit_taken) ||
                       (commit_opcode == op_b_jal) ||
                       (commit_opcode == op_b_jalr));

  // Only branch-relevant commits can be back-pressured; everything else is dropped.
  assign commit_ready = !qualifying || ((state_q == IDLE) && !fifo_full);

  assign fifo_push        = qualifying && commit_ready;
  assign fifo_wdata.op     = is_br ? WR_BR : WR_JMP;
  assign fifo_wdata.pc     = commit_pc;
  assign fifo_wdata.target = commit_pc_next;
  assign fifo_pop         = (state_q == IDLE) && !fifo_empty && btb_wr_ready;
  assign fifo_clear       = (state_q == IDLE) && flush_req;

  btb_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .clear (fifo_clear),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    btb_wr_valid  = 1'b0;
    btb_wr_op     = WR_BR;
    btb_wr_index  = '0;
    btb_wr_pc     = '0;
    btb_wr_target = '0;
    flush_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          btb_wr_valid  = 1'b1;
          btb_wr_op     = fifo_head.op;
          btb_wr_pc     = fifo_head.pc;
          btb_wr_target = fifo_head.target;
        end
      end
      FLUSH: begin
        btb_wr_valid = 1'b1;
        btb_wr_op    = WR_INVAL;
        btb_wr_index = sweep_q;
      end
      DONE: flush_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          sweep_d = '0;
        end
      end
      FLUSH: begin
        if (btb_wr_ready) begin
          sweep_d = sweep_q + BTB_DEPTH'(1);
          if (sweep_q == SweepLast) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: commit filtering, FIFO back-pressure and flush sweeps.
module tb_btb_update_ctrl;
  import rv32im_types::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BTB_DEPTH  = 2;

  logic                 clk;
  logic                 rst;
  logic                 commit_valid;
  logic                 commit_ready;
  logic [31:0]          commit_pc;
  logic [31:0]          commit_pc_next;
  logic [6:0]           commit_opcode;
  logic                 commit_taken;
  logic                 flush_req;
  logic                 flush_done;
  logic                 btb_wr_valid;
  logic                 btb_wr_ready;
  btb_wr_op_t           btb_wr_op;
  logic [BTB_DEPTH-1:0] btb_wr_index;
  logic [31:0]          btb_wr_pc;
  logic [31:0]          btb_wr_target;

  int n_checks = 0;
  int n_fail   = 0;

  btb_update_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BTB_DEPTH  (BTB_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid   (commit_valid),
    .commit_ready   (commit_ready),
    .commit_pc      (commit_pc),
    .commit_pc_next (commit_pc_next),
    .commit_opcode  (commit_opcode),
    .commit_taken   (commit_taken),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .btb_wr_valid   (btb_wr_valid),
    .btb_wr_ready   (btb_wr_ready),
    .btb_wr_op      (btb_wr_op),
    .btb_wr_index   (btb_wr_index),
    .btb_wr_pc      (btb_wr_pc),
    .btb_wr_target  (btb_wr_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; flush_req = 1'b0; btb_wr_ready = 1'b1;
    commit_valid = 1'b1; commit_opcode = op_b_jal; commit_taken = 1'b0;
    commit_pc = 32'h40; commit_pc_next = 32'h80;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (commit_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_commit_ready: got %b want 1", commit_ready); end
    n_checks++; if (btb_wr_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_wr_valid: got %b want 0", btb_wr_valid); end
    n_checks++; if (flush_done !== 1'b0) begin n_fail++;
      $display("FAIL rst_flush_done: got %b want 0", flush_done); end
    n_checks++; if (btb_wr_op !== WR_BR) begin n_fail++;
      $display("FAIL rst_wr_op: got %0d want %0d", btb_wr_op, WR_BR); end
    n_checks++; if (btb_wr_index !== 2'd0 || btb_wr_pc !== 32'h0 || btb_wr_target !== 32'h0)
      begin n_fail++; $display("FAIL rst_wr_data: got idx %0d pc %h tgt %h want 0 0 0",
        btb_wr_index, btb_wr_pc, btb_wr_target); end
    @(negedge clk);
    rst = 1'b0; commit_valid = 1'b0;
  endtask

  task automatic test_taken_branch();
    @(negedge clk);
    btb_wr_ready = 1'b1; commit_valid = 1'b1; commit_opcode = op_b_br; commit_taken = 1'b1;
    commit_pc = 32'h100; commit_pc_next = 32'h200;
    #1;
    n_checks++; if (commit_ready !== 1'b1) begin n_fail++;
      $display("FAIL br_commit_ready: got %b want 1", commit_ready); end
    n_checks++; if (btb_wr_valid !== 1'b0) begin n_fail++;
      $display("FAIL br_no_bypass: got valid %b want 0", btb_wr_valid); end
    @(negedge clk);
    commit_opcode = op_b_jalr; commit_taken = 1'b0;
    commit_pc = 32'h300; commit_pc_next = 32'h340;
    #1;
    n_checks++; if (btb_wr_valid !== 1'b1 || btb_wr_op !== WR_BR || btb_wr_pc !== 32'h100 ||
                    btb_wr_target !== 32'h200) begin n_fail++;
      $display("FAIL br_write: got v%b op%0d pc %h tgt %h want v1 op0 pc 100 tgt 200",
        btb_wr_valid, btb_wr_op, btb_wr_pc, btb_wr_target); end
    @(negedge clk);
    commit_valid = 1'b0;
    #1;
    n_checks++; if (btb_wr_valid !== 1'b1 || btb_wr_op !== WR_JMP || btb_wr_pc !== 32'h300 ||
                    btb_wr_target !== 32'h340) begin n_fail++;
      $display("FAIL jalr_write: got v%b op%0d pc %h tgt %h want v1 op1 pc 300 tgt 340",
        btb_wr_valid, btb_wr_op, btb_wr_pc, btb_wr_target); end
    @(negedge clk);
    #1;
    n_checks++; if (btb_wr_valid !== 1'b0) begin n_fail++;
      $display("FAIL br_drained: got valid %b want 0", btb_wr_valid); end
  endtask

  task automatic test_filtered();
    @(negedge clk);
    commit_valid = 1'b1; commit_opcode = op_b_br; commit_taken = 1'b0;
    commit_pc = 32'h500; commit_pc_next = 32'h504;
    #1;
    n_checks++; if (commit_ready !== 1'b1) begin n_fail++;
      $display("FAIL nt_br_ready: got %b want 1", commit_ready); end
    @(negedge clk);
    commit_opcode = op_b_imm; commit_taken = 1'b1;
    #1;
    n_checks++; if (commit_ready !== 1'b1) begin n_fail++;
      $display("FAIL opimm_ready: got %b want 1", commit_ready); end
    @(negedge clk);
    commit_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (btb_wr_valid !== 1'b0) begin n_fail++;
        $display("FAIL filtered_no_write[%0d]: got valid %b want 0", i, btb_wr_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    btb_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      commit_valid = 1'b1; commit_opcode = op_b_jal; commit_taken = 1'b0;
      commit_pc = 32'h1000 + 32'(i * 4); commit_pc_next = 32'h2000 + 32'(i * 16);
      #1;
      n_checks++; if (commit_ready !== (i < 4)) begin n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b want %b", i, commit_ready, i < 4); end
      if (i >= 1) begin
        n_checks++; if (btb_wr_valid !== 1'b1 || btb_wr_pc !== 32'h1000) begin n_fail++;
          $display("FAIL b2b_stall_hold[%0d]: got v%b pc %h want v1 pc 1000",
            i, btb_wr_valid, btb_wr_pc); end
      end
    end
    @(negedge clk);
    commit_valid = 1'b0;
    #1;
    n_checks++; if (btb_wr_op !== WR_JMP || btb_wr_pc !== 32'h1000 || btb_wr_target !== 32'h2000)
      begin n_fail++; $display("FAIL b2b_stable: got op%0d pc %h tgt %h want op1 pc 1000 tgt 2000",
        btb_wr_op, btb_wr_pc, btb_wr_target); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      btb_wr_ready = 1'b1;
      #1;
      n_checks++; if (btb_wr_valid !== 1'b1 || btb_wr_pc !== 32'h1000 + 32'(j * 4) ||
                      btb_wr_target !== 32'h2000 + 32'(j * 16)) begin n_fail++;
        $display("FAIL b2b_drain[%0d]: got v%b pc %h tgt %h want v1 pc %h tgt %h", j,
          btb_wr_valid, btb_wr_pc, btb_wr_target, 32'h1000 + 32'(j * 4), 32'h2000 + 32'(j * 16));
      end
    end
    @(negedge clk);
    #1;
    n_checks++; if (btb_wr_valid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_empty: got valid %b want 0", btb_wr_valid); end
  endtask

  task automatic test_flush();
    btb_wr_ready = 1'b0;
    @(negedge clk);
    commit_valid = 1'b1; commit_opcode = op_b_jal; commit_pc = 32'hA00; commit_pc_next = 32'hB00;
    @(negedge clk);
    commit_pc = 32'hA10; commit_pc_next = 32'hB10;
    @(negedge clk);
    commit_valid = 1'b0; flush_req = 1'b1; btb_wr_ready = 1'b1;
    #1;
    n_checks++; if (btb_wr_valid !== 1'b1 || btb_wr_pc !== 32'hA00) begin n_fail++;
      $display("FAIL flush_inflight: got v%b pc %h want v1 pc a00", btb_wr_valid, btb_wr_pc); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      commit_valid = 1'b1; commit_opcode = op_b_jal; commit_pc = 32'hC00; commit_pc_next = 32'hD00;
      #1;
      n_checks++; if (commit_ready !== 1'b0) begin n_fail++;
        $display("FAIL flush_commit_stall[%0d]: got %b want 0", k, commit_ready); end
      n_checks++; if (btb_wr_valid !== 1'b1 || btb_wr_op !== WR_INVAL ||
                      btb_wr_index !== 2'(k) || btb_wr_pc !== 32'h0 || btb_wr_target !== 32'h0)
        begin n_fail++;
        $display("FAIL flush_inval[%0d]: got v%b op%0d idx %0d pc %h tgt %h want v1 op2 idx %0d 0 0",
          k, btb_wr_valid, btb_wr_op, btb_wr_index, btb_wr_pc, btb_wr_target, k); end
    end
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    n_checks++; if (flush_done !== 1'b1 || btb_wr_valid !== 1'b0 || commit_ready !== 1'b0)
      begin n_fail++; $display("FAIL flush_done_cycle: got done %b v%b rdy %b want 1 0 0",
        flush_done, btb_wr_valid, commit_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (flush_done !== 1'b0 || btb_wr_valid !== 1'b0 || commit_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_post_idle: got done %b v%b rdy %b want 0 0 1",
        flush_done, btb_wr_valid, commit_ready); end
    @(negedge clk);
    commit_valid = 1'b0;
    #1;
    n_checks++; if (btb_wr_valid !== 1'b1 || btb_wr_pc !== 32'hC00 || btb_wr_target !== 32'hD00)
      begin n_fail++; $display("FAIL flush_dropped: got v%b pc %h tgt %h want v1 pc c00 tgt d00",
        btb_wr_valid, btb_wr_pc, btb_wr_target); end
    @(negedge clk);
    #1;
    n_checks++; if (btb_wr_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_refill_drained: got valid %b want 0", btb_wr_valid); end
  endtask

  task automatic test_flush_stall();
    int done_cnt = 0;
    @(negedge clk);
    flush_req = 1'b1; btb_wr_ready = 1'b0; commit_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      btb_wr_ready = c[0];
      #1;
      if (flush_done === 1'b1) done_cnt++;
      n_checks++; if (btb_wr_valid !== 1'b1 || btb_wr_op !== WR_INVAL ||
                      btb_wr_index !== 2'(c / 2)) begin n_fail++;
        $display("FAIL stall_sweep[%0d]: got v%b op%0d idx %0d want v1 op2 idx %0d",
          c, btb_wr_valid, btb_wr_op, btb_wr_index, c / 2); end
    end
    @(negedge clk);
    flush_req = 1'b0; btb_wr_ready = 1'b1;
    #1;
    if (flush_done === 1'b1) done_cnt++;
    n_checks++; if (flush_done !== 1'b1 || btb_wr_valid !== 1'b0) begin n_fail++;
      $display("FAIL stall_done: got done %b v%b want 1 0", flush_done, btb_wr_valid); end
    repeat (3) begin
      @(negedge clk);
      #1;
      if (flush_done === 1'b1) done_cnt++;
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++;
      $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    flush_req = 1'b1; btb_wr_ready = 1'b1; commit_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_checks++; if (btb_wr_index !== 2'(k) || btb_wr_op !== WR_INVAL) begin n_fail++;
        $display("FAIL rstsweep_idx[%0d]: got idx %0d op%0d want idx %0d op2",
          k, btb_wr_index, btb_wr_op, k); end
    end
    rst = 1'b1; flush_req = 1'b0;
    @(negedge clk);
    commit_valid = 1'b1; commit_opcode = op_b_br; commit_taken = 1'b1;
    commit_pc = 32'hE00; commit_pc_next = 32'hF00;
    #1;
    n_checks++; if (btb_wr_valid !== 1'b0 || flush_done !== 1'b0 || commit_ready !== 1'b1)
      begin n_fail++; $display("FAIL rstsweep_abort: got v%b done %b rdy %b want 0 0 1",
        btb_wr_valid, flush_done, commit_ready); end
    #1;
    rst = 1'b0; commit_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_checks++; if (flush_done !== 1'b0 || btb_wr_valid !== 1'b0) begin n_fail++;
        $display("FAIL rstsweep_quiet[%0d]: got done %b v%b want 0 0",
          i, flush_done, btb_wr_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_taken_branch();
    test_filtered();
    test_back_to_back();
    test_flush();
    test_flush_stall();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Sequences all writes into the branch target buffer. Committed control-flow instructions from the ROB are filtered, buffered in a small FIFO and drained one per cycle over a valid/ready write port. A flush sequencer sweeps every BTB index with invalidate writes on request (fence.i, context switch), blocking commit updates until the sweep ends. Sits between ROB commit and the BTB write side.

## Interface
- FIFO_DEPTH, 4, update FIFO entries; power of two, >= 2
- BTB_DEPTH, 2, BTB index width; BTB holds 2**BTB_DEPTH entries per array
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- commit_valid  in  1  ROB commits an instruction this cycle
- commit_ready  out  1  update accepted; deasserted only for qualifying commits
- commit_pc  in  32  PC of committed instruction
- commit_pc_next  in  32  resolved next PC
- commit_opcode  in  7  opcode of committed instruction
- commit_taken  in  1  resolved direction (branches)
- flush_req  in  1  level request to invalidate BTB; held until flush_done
- flush_done  out  1  one-cycle pulse when sweep completes
- btb_wr_valid  out  1  write request to BTB
- btb_wr_ready  in  1  BTB accepts write this cycle
- btb_wr_op  out  2  btb_wr_op_t: WR_BR, WR_JMP, WR_INVAL
- btb_wr_index  out  BTB_DEPTH  target index; meaningful for WR_INVAL only
- btb_wr_pc  out  32  branch PC
- btb_wr_target  out  32  branch target

## Operation
- Qualifying commit: commit_valid and (opcode op_b_br with commit_taken, or op_b_jal, or op_b_jalr). Non-qualifying commits always see commit_ready=1 and are dropped.
- commit_ready = !qualifying || (state==IDLE && count!=FIFO_DEPTH); combinational.
- Enqueue on qualifying commit_valid && commit_ready: {op = WR_BR for op_b_br else WR_JMP, pc, pc_next}.
- No bypass: full FIFO refuses enqueue even if a dequeue occurs same cycle.
- States: IDLE, FLUSH, DONE.
- IDLE: btb_wr_valid = FIFO non-empty; head drives op/pc/target, btb_wr_index=0. Dequeue on btb_wr_valid && btb_wr_ready. On flush_req, go FLUSH next cycle; FIFO contents discarded (count cleared) on that transition; an in-flight handshake in the same cycle still completes.
- FLUSH: btb_wr_valid=1, op=WR_INVAL, index=sweep counter (starts 0), pc/target=0. Counter increments on handshake; handshake at index 2**BTB_DEPTH-1 moves to DONE. BTB clears br and jr valid bits at that index.
- DONE: flush_done=1 for one cycle, btb_wr_valid=0, return to IDLE. flush_req still high in IDLE starts a new sweep (requester must drop it on flush_done).
- btb_wr_* held stable while btb_wr_valid && !btb_wr_ready.
- Count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset: state IDLE, FIFO empty, sweep counter 0; btb_wr_valid=0, flush_done=0, btb_wr_op=WR_BR, btb_wr_index/pc/target=0, commit_ready=1 for all commits.
- Enqueue at cycle N -> earliest btb_wr_valid at N+1 (registered FIFO).
- Throughput: one BTB write per cycle with btb_wr_ready=1.
- flush_req sampled at N in IDLE -> first WR_INVAL at N+1; with ready always high, flush_done at N+1+2**BTB_DEPTH.
- rst mid-sweep: sweep aborted, no flush_done, BTB contents left partial (BTB resets itself).

## Structure
- rv32im_types: add btb_wr_op_t enum (WR_BR, WR_JMP, WR_INVAL); op_b_br/op_b_jal/op_b_jalr already there.
- Sub-module btb_upd_fifo: parameterised sync FIFO (push/pop/full/empty/clear), entry = {btb_wr_op_t, 32b pc, 32b target}.
- FSM, filter and sweep counter in btb_update_ctrl.

## Test plan
- Taken op_b_br pc=0x100 next=0x200, ready=1 -> next cycle WR_BR pc=0x100 target=0x200, one cycle valid.
- Not-taken op_b_br and an op_imm commit -> commit_ready=1, no BTB write ever issued.
- Five op_b_jal commits back-to-back, btb_wr_ready=0 -> four accepted, fifth sees commit_ready=0; ready high -> four writes in order, data stable while stalled.
- flush_req with 2 entries queued, BTB_DEPTH=2, ready=1 -> entries dropped, WR_INVAL index 0,1,2,3 on consecutive cycles, flush_done one cycle later; qualifying commits stalled throughout.
- Sweep with btb_wr_ready toggling every other cycle -> each index held until accepted, no skipped index, flush_done exactly once.
- rst asserted at sweep index 2 -> next cycle btb_wr_valid=0, no flush_done, commit_ready=1.
